// File: rtl/apb_master.sv
// APB requester: takes one request at a time, runs SETUP/ACCESS on the bus and
// returns a single-cycle response. A wait-state limit aborts stalled transfers.
module apb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PSELx,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        ready_q, ready_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    ready_d      = ready_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        // ready_q is low for one cycle after reset, so no accept happens then
        ready_d = 1'b1;
        if (ready_q && i_req_valid) begin
          ready_d    = 1'b0;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = i_req_write;
          paddr_d    = i_req_addr;
          pwdata_d   = i_req_wdata;
          wait_cnt_d = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          state_d      = S_IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          ready_d      = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = PSLVERR;
          resp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // this stalled cycle brings the count to TIMEOUT: abort with error
          wait_cnt_d   = wait_cnt_q + 8'd1;
          state_d      = S_IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          ready_d      = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      ready_q      <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      ready_q      <= ready_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign o_req_ready  = ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_err   = resp_err_q;
  assign o_resp_rdata = resp_rdata_q;
  assign PADDR        = paddr_q;
  assign PWRITE       = pwrite_q;
  assign PWDATA       = pwdata_q;
  assign PSELx        = psel_q;
  assign PENABLE      = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a transfer-timeline model predicts every output each
// cycle; directed transfers pin latencies and response values with literals.
module tb_apb_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSELx;
  logic        PENABLE;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  apb_master #(.TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSELx(PSELx), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: a transfer is described by its accept cycle m_a and end cycle m_e
  // (last ACCESS cycle, -1 while unresolved); outputs follow from those.
  logic        m_act = 1'b0;
  int          m_a = 0;
  int          m_e = -1;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic        m_err = 1'b0;
  logic        e_rdy = 1'b0, e_psel = 1'b0, e_pen = 1'b0, e_rv = 1'b0;

  // Response monitor
  int          resp_cnt = 0;
  int          last_resp_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  // Slave behaviour: 0 random, 1 ready after wt wait states, 2 never ready
  int          mode = 0;
  int          wt = 0;
  logic [31:0] d_rdata = '0;
  logic        d_err = 1'b0;
  int          acc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int  cur;
    int  n;
    logic in_x;
    cur = cyc;
    if (i_reset) begin
      m_act = 1'b0; m_e = -1;
      m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
      cyc = cur + 1;
      e_rdy = 1'b0; e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0;
      return;
    end
    if (m_act && m_e < 0 && cur >= m_a + 2) begin
      if (PREADY) begin
        m_e = cur; m_err = PSLVERR; m_rdata = m_wr ? 32'h0 : PRDATA;
      end else if (cur - (m_a + 2) + 1 == TMO) begin
        m_e = cur; m_err = 1'b1; m_rdata = '0;
      end
    end
    if (e_rdy && i_req_valid) begin
      m_act = 1'b1; m_a = cur; m_e = -1;
      m_wr = i_req_write; m_addr = i_req_addr; m_wdata = i_req_wdata;
    end
    cyc = cur + 1;
    n = cyc;
    in_x   = m_act && n >= m_a + 1 && (m_e < 0 || n <= m_e);
    e_psel = in_x;
    e_pen  = in_x && n >= m_a + 2;
    e_rv   = m_act && m_e >= 0 && n == m_e + 1;
    e_rdy  = !in_x;
  endtask

  task automatic compare();
    chk("o_req_ready", {31'b0, o_req_ready}, {31'b0, e_rdy});
    chk("PSELx", {31'b0, PSELx}, {31'b0, e_psel});
    chk("PENABLE", {31'b0, PENABLE}, {31'b0, e_pen});
    chk("o_resp_valid", {31'b0, o_resp_valid}, {31'b0, e_rv});
    chk("o_resp_err", {31'b0, o_resp_err}, {31'b0, m_err});
    chk("o_resp_rdata", o_resp_rdata, m_rdata);
    chk("PADDR", PADDR, m_addr);
    chk("PWRITE", {31'b0, PWRITE}, {31'b0, m_wr});
    chk("PWDATA", PWDATA, m_wdata);
    if (o_resp_valid === 1'b1) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      last_rdata = o_resp_rdata;
      last_err = o_resp_err;
    end
  endtask

  task automatic drive_slave();
    if (PSELx === 1'b1 && PENABLE === 1'b1) acc_n++;
    else acc_n = 0;
    if (mode == 1 && acc_n > wt) begin
      PREADY = 1'b1; PRDATA = d_rdata; PSLVERR = d_err;
    end else if (mode == 0) begin
      PREADY = ($urandom % 4) == 0; PRDATA = $urandom; PSLVERR = $urandom % 2;
    end else begin
      PREADY = 1'b0; PRDATA = $urandom; PSLVERR = $urandom % 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    drive_slave();
  endtask

  task automatic wait_ready(input string nm);
    int k;
    for (k = 0; k < 50 && o_req_ready !== 1'b1; k++) tick();
    if (o_req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s ready_wait actual=0 expected=1", nm);
    end
  endtask

  task automatic do_xfer(input string nm, input logic w, input logic [31:0] addr,
                         input logic [31:0] wdata, input int md, input int wst,
                         input logic [31:0] drd, input logic derr, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_rd);
    int acc;
    int base;
    mode = md; wt = wst; d_rdata = drd; d_err = derr;
    wait_ready(nm);
    i_req_valid = 1'b1; i_req_write = w; i_req_addr = addr; i_req_wdata = wdata;
    acc = cyc; base = resp_cnt;
    tick();
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom;
    for (int k = 0; k < 40 && resp_cnt == base; k++) tick();
    if (resp_cnt == base) begin
      checks++; failures++;
      $display("FAIL %s resp_wait actual=none expected=response", nm);
    end else begin
      chk({nm, "_latency"}, 32'(last_resp_cyc - acc), 32'(exp_lat));
      chk({nm, "_err"}, {31'b0, last_err}, {31'b0, exp_err});
      chk({nm, "_rdata"}, last_rdata, exp_rd);
      chk({nm, "_paddr_held"}, PADDR, addr);
      tick();
      chk({nm, "_single_pulse"}, {31'b0, o_resp_valid}, 32'h0);
    end
  endtask

  initial begin
    int acc1;
    int base;
    int r1;
    logic dropped;
    repeat (3) tick();
    chk("rst_ready", {31'b0, o_req_ready}, 32'h0);
    chk("rst_psel", {31'b0, PSELx}, 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    i_reset = 1'b0;
    tick();
    chk("ready_after_rst", {31'b0, o_req_ready}, 32'h1);

    do_xfer("wr_nowait", 1'b1, 32'h10, 32'hDEADBEEF, 1, 0, 32'h5555AAAA, 1'b0, 3, 1'b0, 32'h0);
    do_xfer("rd_3wait", 1'b0, 32'h10, 32'h0, 1, 3, 32'hDEADBEEF, 1'b0, 6, 1'b0, 32'hDEADBEEF);
    do_xfer("slverr", 1'b0, 32'hFFFFFFFF, 32'h0, 1, 0, 32'h12345678, 1'b1, 3, 1'b1, 32'h12345678);
    do_xfer("timeout", 1'b0, 32'h20, 32'h0, 2, 0, 32'h0, 1'b0, 18, 1'b1, 32'h0);
    do_xfer("ready_at_limit", 1'b0, 32'h30, 32'h0, 1, 15, 32'hCAFEF00D, 1'b0, 18, 1'b0, 32'hCAFEF00D);

    // back-to-back writes with request held valid
    mode = 1; wt = 0; d_err = 1'b0;
    wait_ready("b2b");
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 32'h100; i_req_wdata = 32'h11111111;
    acc1 = cyc; base = resp_cnt; r1 = 0; dropped = 1'b0;
    tick();
    i_req_addr = 32'h104; i_req_wdata = 32'h22222222;
    for (int k = 0; k < 40 && resp_cnt < base + 2; k++) begin
      tick();
      if (resp_cnt == base + 1 && !dropped) begin
        r1 = last_resp_cyc;
        tick();
        i_req_valid = 1'b0;
        dropped = 1'b1;
      end
    end
    chk("b2b_first_lat", 32'(r1 - acc1), 32'd3);
    chk("b2b_second_lat", 32'(last_resp_cyc - acc1), 32'd6);
    chk("b2b_count", 32'(resp_cnt - base), 32'd2);

    // reset during ACCESS wait states
    mode = 2;
    wait_ready("rst_mid");
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h40;
    tick();
    i_req_valid = 1'b0;
    repeat (5) tick();
    chk("rst_mid_in_access", {31'b0, PENABLE}, 32'h1);
    i_reset = 1'b1;
    base = resp_cnt;
    tick();
    chk("rst_mid_psel", {31'b0, PSELx}, 32'h0);
    i_reset = 1'b0;
    repeat (20) tick();
    chk("rst_mid_no_resp", 32'(resp_cnt - base), 32'h0);
    do_xfer("after_rst", 1'b1, 32'h44, 32'hA5A5A5A5, 1, 1, 32'h0, 1'b0, 4, 1'b0, 32'h0);

    // randomized traffic, slave and occasional resets
    mode = 0;
    for (int k = 0; k < 4000; k++) begin
      i_reset = ($urandom % 300) == 0;
      i_req_valid = $urandom % 2;
      i_req_write = $urandom % 2;
      i_req_addr = $urandom;
      i_req_wdata = $urandom;
      tick();
    end
    i_reset = 1'b0;
    i_req_valid = 1'b0;
    repeat (30) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
